// File: rtl/mprc_writeback_unit_pkg.sv
// Shared types and widths for the dirty-line writeback unit.
// Tag/index/way geometry matches the stage-1 metadata and data arrays.
package mprc_writeback_unit_pkg;

  localparam int TAG_W      = 20;
  localparam int IDX_W      = 6;
  localparam int WAYS       = 4;
  localparam int COH_W      = 2;
  localparam int BLOCK_W    = TAG_W + IDX_W;
  localparam int ROW_W      = 128;
  localparam int BEAT_OFF_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } wb_state_t;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [WAYS-1:0]    way_en_t;
  typedef logic [COH_W-1:0]   coh_t;
  typedef logic [BLOCK_W-1:0] block_addr_t;
  typedef logic [ROW_W-1:0]   row_t;

  function automatic block_addr_t block_addr(input tag_t tag, input idx_t idx);
    return {tag, idx};
  endfunction

endpackage

// File: rtl/mprc_wb_beat_queue.sv
// Small FIFO of {beat, row} entries between data-array capture and the release channel.
// Push and pop in the same cycle leave the occupancy unchanged.
module mprc_wb_beat_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 130
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: only entries counted in r_count are ever read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mprc_writeback_unit.sv
// Evicts one dirty line: metadata read, BEATS data-row reads, then BEATS release beats.
// Handshake: a transfer happens on a cycle where valid and ready are both high; valid never waits on ready.
module mprc_writeback_unit
  import mprc_writeback_unit_pkg::*;
#(
  parameter int BEATS     = 4,
  parameter int ROW_BITS  = 128,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [TAG_W-1:0]                          req_tag,
  input  logic [IDX_W-1:0]                          req_idx,
  input  logic [WAYS-1:0]                           req_way_en,
  input  logic [COH_W-1:0]                          req_coh_state,
  output logic                                      meta_read_valid,
  input  logic                                      meta_read_ready,
  output logic [TAG_W-1:0]                          meta_read_tag,
  output logic [IDX_W-1:0]                          meta_read_idx,
  output logic                                      data_req_valid,
  input  logic                                      data_req_ready,
  output logic [WAYS-1:0]                           data_req_way_en,
  output logic [IDX_W+$clog2(BEATS)+BEAT_OFF_W-1:0] data_req_addr,
  input  logic [ROW_BITS-1:0]                       data_resp_0,
  input  logic [ROW_BITS-1:0]                       data_resp_1,
  input  logic [ROW_BITS-1:0]                       data_resp_2,
  input  logic [ROW_BITS-1:0]                       data_resp_3,
  output logic                                      release_valid,
  input  logic                                      release_ready,
  output logic [BLOCK_W-1:0]                        release_addr_block,
  output logic [$clog2(BEATS)-1:0]                  release_beat,
  output logic [ROW_BITS-1:0]                       release_data,
  output logic [COH_W-1:0]                          release_coh_state,
  output logic                                      release_last,
  output logic                                      busy_idx_valid,
  output logic [IDX_W-1:0]                          busy_idx,
  output logic [1:0]                                dbg_state
);

  localparam int BEAT_W  = $clog2(BEATS);
  localparam int CNT_W   = BEAT_W + 1;
  localparam int QCNT_W  = $clog2(BUF_DEPTH+1);
  localparam int ENTRY_W = BEAT_W + ROW_BITS;

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WAYS-1:0]   r_way_en;
  logic [COH_W-1:0]  r_coh;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_send_cnt;
  logic              r_resp_pending;
  logic [BEAT_W-1:0] r_resp_beat;

  logic [ENTRY_W-1:0] w_head;
  logic [QCNT_W-1:0]  w_q_count;
  logic               w_q_empty;
  logic [QCNT_W:0]    w_occ;
  logic               w_space_ok;
  logic               w_accept;
  logic               w_pop;
  logic               w_last_pop;
  logic [ROW_BITS-1:0] w_row;

  // A beat leaving this cycle frees its slot before the new response lands.
  assign w_occ      = {1'b0, w_q_count} + (QCNT_W+1)'(r_resp_pending) - (QCNT_W+1)'(w_pop);
  assign w_space_ok = (w_occ < (QCNT_W+1)'(BUF_DEPTH));

  assign req_ready       = (r_state == IDLE);
  assign meta_read_valid = (r_state == META);
  assign data_req_valid  = (r_state == DATA) && (r_issue_cnt < CNT_W'(BEATS)) && w_space_ok;
  assign w_accept        = data_req_valid && data_req_ready;
  assign release_valid   = !w_q_empty;
  assign w_pop           = release_valid && release_ready;
  assign w_last_pop      = w_pop && (r_send_cnt == CNT_W'(BEATS-1));

  assign meta_read_tag      = r_tag;
  assign meta_read_idx      = r_idx;
  assign data_req_way_en    = r_way_en;
  assign data_req_addr      = {r_idx, r_issue_cnt[BEAT_W-1:0], BEAT_OFF_W'(0)};
  assign release_addr_block = block_addr(r_tag, r_idx);
  assign release_coh_state  = r_coh;
  assign release_beat       = w_head[ENTRY_W-1 -: BEAT_W];
  assign release_data       = w_head[ROW_BITS-1:0];
  assign release_last       = (release_beat == BEAT_W'(BEATS-1));
  assign busy_idx_valid     = (r_state != IDLE);
  assign busy_idx           = r_idx;
  assign dbg_state          = r_state;

  assign w_row = ({ROW_BITS{r_way_en[0]}} & data_resp_0) |
                 ({ROW_BITS{r_way_en[1]}} & data_resp_1) |
                 ({ROW_BITS{r_way_en[2]}} & data_resp_2) |
                 ({ROW_BITS{r_way_en[3]}} & data_resp_3);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = META;
      META:    if (meta_read_ready) w_state_nxt = DATA;
      DATA:    if (w_last_pop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_tag          <= '0;
      r_idx          <= '0;
      r_way_en       <= '0;
      r_coh          <= '0;
      r_issue_cnt    <= '0;
      r_send_cnt     <= '0;
      r_resp_pending <= 1'b0;
      r_resp_beat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && req_valid) begin
        r_tag       <= req_tag;
        r_idx       <= req_idx;
        r_way_en    <= req_way_en;
        r_coh       <= req_coh_state;
        r_issue_cnt <= '0;
        r_send_cnt  <= '0;
      end
      if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_resp_beat <= r_issue_cnt[BEAT_W-1:0];
      end
      // The array answers exactly one cycle after each accepted read.
      r_resp_pending <= w_accept;
      if (w_pop) r_send_cnt <= r_send_cnt + 1'b1;
    end
  end

  mprc_wb_beat_queue #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_beat_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_resp_pending),
    .i_push_data ({r_resp_beat, w_row}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_q_count),
    .o_empty     (w_q_empty)
  );

endmodule
